// File: rtl/capture_readback.sv
// Streams stored capture samples out of the sample BRAM in address order onto a
// valid/ready stream, absorbing read latency and backpressure with a credited FIFO.
module capture_readback #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   count,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W:0]   count_lat;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   pop_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [RD_LAT-1:0] vld_p;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     in_flight;
    logic              issue_start;
    logic              issue_run;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              abort_now;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(vld_p[i]);

        // The first read goes out in the start cycle so data arrives RD_LAT+1 cycles later.
        issue_start = (state == IDLE) && start && (count != '0);
        issue_run   = (state == RUN) && !abort && ((in_flight + occ) < CW'(FIFO_DEPTH));
        ram_en      = issue_start || issue_run;
        ram_addr    = rd_addr;

        push      = vld_p[RD_LAT-1];
        m_valid   = (occ != '0);
        m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
        m_last    = m_valid && (pop_cnt == count_lat - ONE);
        pop       = m_valid && m_ready;
        last_pop  = pop && m_last;
        abort_now = abort && (state != IDLE) && !last_pop;
        busy      = (state != IDLE);
    end

    // Return stage: data is captured into the FIFO as it emerges from the BRAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count_lat <= '0;
            remaining <= '0;
            pop_cnt   <= '0;
            rd_addr   <= '0;
            vld_p     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            vld_p[0] <= issue_start || issue_run;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];

            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr  <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                pop_cnt <= pop_cnt + ONE;
            end
            occ <= occ + CW'(push) - CW'(pop);

            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            count_lat <= count;
                            remaining <= count - ONE;
                            pop_cnt   <= '0;
                            if (count == ONE) begin
                                state <= DRAIN;
                            end else begin
                                state   <= RUN;
                                rd_addr <= ADDR_W'(1);
                            end
                        end
                    end
                end
                RUN: begin
                    if (issue_run) begin
                        remaining <= remaining - ONE;
                        // Hold the address on the final issue so it never wraps.
                        if (remaining == ONE) state <= DRAIN;
                        else rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase

            if (last_pop) begin
                done    <= 1'b1;
                state   <= IDLE;
                rd_addr <= '0;
            end else if (abort_now) begin
                aborted <= 1'b1;
                state   <= IDLE;
                rd_addr <= '0;
                vld_p   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_capture_readback.sv
// Directed bench for capture_readback: table of streaming scenarios plus
// hand-written abort, zero-count, reset and full-address-range sequences.
module tb_capture_readback;

    localparam int AW = 18;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int SAW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, abort, m_ready;
    logic [AW:0]   count;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, busy, done, aborted;

    logic           s_start, s_abort, s_m_ready;
    logic [SAW:0]   s_count;
    logic           s_ram_en;
    logic [SAW-1:0] s_ram_addr;
    logic [DW-1:0]  s_ram_data, s_q1;
    logic [DW-1:0]  s_m_data;
    logic           s_m_valid, s_m_last, s_busy, s_done, s_aborted;

    capture_readback #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .count(count),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done), .aborted(aborted)
    );

    capture_readback #(.ADDR_W(SAW), .DATA_W(DW), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .count(s_count),
        .ram_en(s_ram_en), .ram_addr(s_ram_addr), .ram_data(s_ram_data),
        .m_data(s_m_data), .m_valid(s_m_valid), .m_last(s_m_last), .m_ready(s_m_ready),
        .busy(s_busy), .done(s_done), .aborted(s_aborted)
    );

    // BRAM contents: address a holds (a+1)*0x11, so 0..4 -> 0x11..0x55.
    function automatic logic [7:0] bram_val(input int a);
        return 8'((a + 1) * 17);
    endfunction

    always @(posedge clk) if (ram_en) ram_data <= bram_val(int'(ram_addr));
    always @(posedge clk) begin
        s_q1       <= bram_val(int'(s_ram_addr));
        s_ram_data <= s_q1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            1:       return (c % 2) == 0;
            2:       return c >= 20;
            default: return 1'b1;
        endcase
    endfunction

    typedef struct {
        int cnt;
        int mode;
        int exp_first_vld;
        int exp_span;
        int exp_max_out;
        int exp_pre_pop;
    } vec_t;

    int r_words, r_dones, r_lasts, r_first, r_lastpop, r_maxout, r_prepop, r_donec;

    task automatic run_case(input int cnt, input int mode);
        int   issues = 0;
        int   pops = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] held = '0;
        r_dones = 0; r_lasts = 0; r_first = -1; r_lastpop = -1;
        r_maxout = 0; r_prepop = -1; r_donec = -1;
        @(posedge clk); #1;
        count = (AW + 1)'(cnt); start = 1'b1; m_ready = ready_for(mode, 0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, held);
            end
            if (ram_en) begin
                check("ram_addr_seq", ram_addr, issues);
                issues++;
            end
            if (m_valid && r_first < 0) r_first = c;
            if (m_valid && m_ready) begin
                check("word_data", m_data, bram_val(pops));
                check("word_last", m_last, pops == cnt - 1);
                if (m_last) r_lasts++;
                pops++;
                r_lastpop = c;
                if (r_prepop < 0) r_prepop = issues;
            end
            if (issues - pops > r_maxout) r_maxout = issues - pops;
            if (done) begin
                r_dones++;
                if (r_donec < 0) r_donec = c;
            end
            stalled = m_valid && !m_ready;
            held = m_data;
            @(posedge clk); #1;
            start = 1'b0;
            m_ready = ready_for(mode, c + 1);
            if (r_donec >= 0 && c >= r_donec + 3) break;
        end
        r_words = pops;
    endtask

    initial begin
        vec_t tbl[5];
        int   hs, dn, ab, ens, vl, dc;
        int   issues, pops, last_addr, first_v, lastpop, dones, donec, lasts;

        tbl[0] = '{cnt: 5, mode: 0, exp_first_vld: 2, exp_span: 4,  exp_max_out: 2, exp_pre_pop: 3};
        tbl[1] = '{cnt: 8, mode: 1, exp_first_vld: 2, exp_span: 14, exp_max_out: 4, exp_pre_pop: 3};
        tbl[2] = '{cnt: 6, mode: 2, exp_first_vld: 2, exp_span: 23, exp_max_out: 4, exp_pre_pop: 4};
        tbl[3] = '{cnt: 1, mode: 0, exp_first_vld: 2, exp_span: 0,  exp_max_out: 1, exp_pre_pop: 1};
        tbl[4] = '{cnt: 2, mode: 0, exp_first_vld: 2, exp_span: 1,  exp_max_out: 2, exp_pre_pop: 2};

        reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; count = '0;
        s_start = 1'b0; s_abort = 1'b0; s_m_ready = 1'b1; s_count = '0;
        #12;
        check("reset_outputs", {ram_en, ram_addr, m_valid, m_last, m_data, busy, done, aborted}, 0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_case(tbl[i].cnt, tbl[i].mode);
            check("tbl_words", r_words, tbl[i].cnt);
            check("tbl_dones", r_dones, 1);
            check("tbl_lasts", r_lasts, 1);
            check("tbl_first_valid", r_first, tbl[i].exp_first_vld);
            check("tbl_span", r_lastpop - r_first, tbl[i].exp_span);
            check("tbl_max_outstanding", r_maxout, tbl[i].exp_max_out);
            check("tbl_issues_at_first_pop", r_prepop, tbl[i].exp_pre_pop);
            check("tbl_done_timing", r_donec, r_lastpop + 1);
            check("tbl_busy_after", busy, 0);
        end

        // count == 0: done next cycle, nothing read or streamed.
        @(posedge clk); #1 count = '0; start = 1'b1; m_ready = 1'b1;
        dn = 0; ens = 0; vl = 0; dc = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_en) ens++;
            if (m_valid) vl++;
            if (done) begin dn++; dc = c; end
            @(posedge clk); #1 start = 1'b0;
        end
        check("zero_done_count", dn, 1);
        check("zero_done_cycle", dc, 1);
        check("zero_ram_en", ens, 0);
        check("zero_m_valid", vl, 0);

        // Abort after three handshakes, then a clean short readback.
        @(posedge clk); #1 count = 19'd10; start = 1'b1; m_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) hs++;
            if (hs == 3) break;
            @(posedge clk); #1 start = 1'b0;
        end
        check("abort_handshakes_seen", hs, 3);
        @(posedge clk); #1 start = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_pulse", aborted, 1);
        check("abort_m_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        dn = 0; ab = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (aborted) ab++;
            @(posedge clk); #1;
        end
        check("abort_later_done", dn, 0);
        check("abort_single_pulse", ab, 0);
        run_case(2, 0);
        check("post_abort_words", r_words, 2);
        check("post_abort_done", r_dones, 1);

        // Abort in the same cycle as the final handshake: done wins.
        @(posedge clk); #1 count = 19'd1; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        check("final_hs_last", {m_valid, m_last}, 2'b11);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("final_hs_done", done, 1);
        check("final_hs_no_abort", aborted, 0);
        check("final_hs_idle", busy, 0);

        // Abort while idle is ignored.
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ignored", aborted, 0);

        // Asynchronous reset in the middle of a full-size run with the stream stalled.
        @(posedge clk); #1 count = 19'h40000; start = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("pre_reset_busy_valid", {busy, m_valid}, 2'b11);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {ram_en, ram_addr, m_valid, m_last, m_data, busy, done, aborted}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Full address range on the RD_LAT=2 instance.
        issues = 0; pops = 0; last_addr = -1; first_v = -1; lastpop = -1;
        dones = 0; donec = -1; lasts = 0;
        @(posedge clk); #1 s_count = 11'd1024; s_start = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (s_ram_en) begin
                if (s_ram_addr != SAW'(issues)) check("full_addr_seq", s_ram_addr, issues);
                last_addr = int'(s_ram_addr);
                issues++;
            end
            if (s_m_valid && first_v < 0) first_v = c;
            if (s_m_valid && s_m_ready) begin
                if (s_m_data != bram_val(pops)) check("full_data", s_m_data, bram_val(pops));
                if (s_m_last != (pops == 1023)) check("full_last_pos", s_m_last, pops == 1023);
                if (s_m_last) lasts++;
                pops++;
                lastpop = c;
            end
            if (s_done) begin dones++; if (donec < 0) donec = c; end
            @(posedge clk); #1 s_start = 1'b0;
            if (donec >= 0 && c >= donec + 3) break;
        end
        check("full_issues", issues, 1024);
        check("full_last_addr", last_addr, 32'h3FF);
        check("full_words", pops, 1024);
        check("full_lasts", lasts, 1);
        check("full_first_valid", first_v, 3);
        check("full_done_count", dones, 1);
        check("full_done_timing", donec, lastpop + 1);
        check("full_throughput", lastpop - first_v, 1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_readback.md
Name: capture_readback

Overview:
- Reader for the logic-capture sample buffer: after a capture stops, streams the stored 8-bit transition samples out of the capture BRAM in address order.
- Each stored sample becomes one word on a valid/ready stream consumed by the host-side transport (UART or register window).
- Owns the BRAM read port (en/address/data); the capture block owns the write port.
- Absorbs BRAM read latency and downstream backpressure with a credit-controlled internal FIFO.

Parameters:
ADDR_W, 18, BRAM address width (262144 entries)
DATA_W, 8, sample width
RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2
FIFO_DEPTH, 4, internal output FIFO entries; must be >= RD_LAT+2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin readback
abort  in  1  one-cycle pulse: cancel readback
count  in  ADDR_W+1  number of samples to read (0..2^ADDR_W); sampled on accepted start
ram_en  out  1  BRAM read enable
ram_addr  out  ADDR_W  BRAM read address
ram_data  in  DATA_W  BRAM read data, valid RD_LAT cycles after ram_en
m_data  out  DATA_W  stream data
m_valid  out  1  stream valid
m_last  out  1  marks final sample of the readback
m_ready  in  1  downstream ready
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when final sample handshakes
aborted  out  1  one-cycle pulse when an abort takes effect

Behaviour:
- Reset (async, active-high): state=IDLE. ram_en=0, ram_addr=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, aborted=0. FIFO empty; read-latency pipe cleared.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with count>0: latch count into remaining, rd_addr=0, go RUN.
  - start with count==0: pulse done next cycle, stay IDLE, never assert m_valid.
- RUN:
  - Issue a read (ram_en=1, ram_addr=rd_addr) in any cycle where in_flight + fifo_occupancy < FIFO_DEPTH.
  - Per issue: rd_addr+1, remaining-1. After issuing address count-1, go DRAIN.
  - ram_en is 0 in every cycle without an issue.
  - rd_addr never exceeds count-1; no wrap.
- Read return: RD_LAT cycles after each issue, ram_data is pushed into the FIFO. A shift-register valid pipe of length RD_LAT tracks in-flight reads. The credit rule guarantees the FIFO never overflows.
- Stream output:
  - m_valid = FIFO not empty; m_data = FIFO head (first-word-fall-through).
  - Pop on m_valid&&m_ready.
  - m_data/m_valid are stable while m_valid&&!m_ready.
- m_last is asserted with the sample read from address count-1 only. It is tracked by counting popped words against the latched count.
- DRAIN: no issues. On handshake of the m_last word: done=1 for one cycle, go IDLE.
- Throughput: with m_ready held high, one word per cycle sustained. First m_valid appears RD_LAT+1 cycles after the start pulse.
- abort, in RUN or DRAIN:
  - Next cycle: state=IDLE, FIFO flushed, in-flight returns discarded, m_valid=0, aborted=1 for one cycle.
  - done is not pulsed.
  - abort in IDLE is ignored (no aborted pulse).
- start while busy: ignored.
- start and abort in the same cycle: abort wins if busy; start honoured if IDLE.
- Final handshake and abort in the same cycle: the handshake completes, done pulses, aborted is not pulsed.
- count is only sampled on an accepted start; later changes have no effect.

Test Plan:
- count=5, BRAM[0..4]=0x11,0x22,0x33,0x44,0x55, m_ready=1, RD_LAT=1 -> m_data 0x11..0x55 on 5 consecutive cycles, m_last only with 0x55, single done pulse, ram_addr sequence 0..4 each once.
- count=8, m_ready toggling 1010... -> all 8 words in order, none duplicated or dropped, data stable while stalled, ram_en never issues a 5th outstanding read beyond FIFO_DEPTH credit.
- count=6, m_ready=0 for 20 cycles, then 1 -> exactly 4 reads issued then ram_en=0, FIFO holds 4, then all 6 delivered, done after 6th.
- count=0 start -> done pulse next cycle, m_valid never asserted, ram_en never asserted.
- count=10, abort after 3 handshakes -> aborted pulse, m_valid=0 next cycle, no done, busy=0; a following start count=2 returns BRAM[0],BRAM[1] only (no stale data).
- Async reset asserted mid-RUN with count=2^18 -> all outputs at reset values immediately. Repeat the full 262144-word run with RD_LAT=2 -> last ram_addr=0x3FFFF, no wrap, m_last on word 262144.
